// File: rtl/cdb_arbiter.sv
// cdb_arbiter: shares one registered common data bus among three result
// producers (ALU1, ALU2, LSB). Each producer owns a small circular queue; a
// round-robin scheduler broadcasts at most one entry per cycle.
// Optional feature macro: CDB_BYPASS_EN. When defined, an incoming entry on an
// empty queue may win arbitration in the same cycle and skip the queue.
module cdb_arbiter #(
    parameter int DATA_W   = 32,
    parameter int ROB_ID_W = 5,
    parameter int QDEPTH   = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  rdy_i,
    input  logic                  rollback_flag_i,
    input  logic [2:0]            req_valid_i,
    input  logic [3*ROB_ID_W-1:0] req_rob_id_i,
    input  logic [3*DATA_W-1:0]   req_result_i,
    output logic [2:0]            req_ready_o,
    output logic                  cdb_valid_o,
    output logic [ROB_ID_W-1:0]   cdb_rob_id_o,
    output logic [DATA_W-1:0]     cdb_result_o,
    output logic [1:0]            cdb_src_o
);

    localparam int PTR_W = $clog2(QDEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = ROB_ID_W + DATA_W;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(QDEPTH);

    // Next requester index in round-robin order (2 wraps to 0).
    function automatic logic [1:0] inc3(input logic [1:0] v);
        return (v == 2'd2) ? 2'd0 : v + 2'd1;
    endfunction

    // Normal operation only when enabled and not flushing.
    logic advance;
    assign advance = rdy_i & ~rollback_flag_i;

    logic [2:0]            nonempty;
    logic [2:0]            push;
    logic [2:0]            enq;
    logic [2:0]            pop;
    logic [2:0]            cand;
    logic [2:0][ENT_W-1:0] head_ent;
    logic [2:0][ENT_W-1:0] in_ent;

    logic                  win_valid;
    logic [1:0]            win_idx;
    logic [1:0]            scan_idx;
    logic [ENT_W-1:0]      win_ent;

    logic [1:0]            rr_q, rr_d;
    logic                  cdb_valid_q, cdb_valid_d;
    logic [ROB_ID_W-1:0]   cdb_rob_id_q, cdb_rob_id_d;
    logic [DATA_W-1:0]     cdb_result_q, cdb_result_d;
    logic [1:0]            cdb_src_q, cdb_src_d;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_queue
            logic [ENT_W-1:0] mem_q [QDEPTH];
            logic [PTR_W-1:0] head_q;
            logic [PTR_W-1:0] tail_q;
            logic [CNT_W-1:0] count_q;

            assign in_ent[gi]      = {req_rob_id_i[gi*ROB_ID_W +: ROB_ID_W],
                                      req_result_i[gi*DATA_W +: DATA_W]};
            assign head_ent[gi]    = mem_q[head_q];
            assign nonempty[gi]    = (count_q != '0);
            // Ready looks only at registered occupancy, so a full queue never
            // accepts a push even if it is being popped this same edge.
            assign req_ready_o[gi] = advance & (count_q < FULL_CNT);
            assign push[gi]        = req_valid_i[gi] & req_ready_o[gi];
`ifdef CDB_BYPASS_EN
            // An empty queue competes with its incoming entry directly.
            assign cand[gi]        = nonempty[gi] | push[gi];
`else
            assign cand[gi]        = nonempty[gi];
`endif
            assign pop[gi]         = advance & win_valid & (win_idx == 2'(gi)) & nonempty[gi];
            // A bypass winner (empty queue wins) goes straight to the bus.
            assign enq[gi]         = push[gi] & ~(advance & win_valid &
                                     (win_idx == 2'(gi)) & ~nonempty[gi]);

            // Queue pointers and occupancy; flush on rollback, hold when stalled.
            always_ff @(posedge clk_i) begin
                if (!rst_i) begin
                    head_q  <= '0;
                    tail_q  <= '0;
                    count_q <= '0;
                end else if (rollback_flag_i) begin
                    head_q  <= '0;
                    tail_q  <= '0;
                    count_q <= '0;
                end else if (rdy_i) begin
                    if (enq[gi]) tail_q <= tail_q + 1'b1;
                    if (pop[gi]) head_q <= head_q + 1'b1;
                    count_q <= count_q + CNT_W'(enq[gi]) - CNT_W'(pop[gi]);
                end
            end

            // Entry storage, written at the tail on every accepted push.
            always_ff @(posedge clk_i) begin
                if (enq[gi]) mem_q[tail_q] <= in_ent[gi];
            end
        end
    endgenerate

    // Round-robin search starting at the pointer; first candidate wins.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = 2'd0;
        scan_idx  = rr_q;
        for (int k = 0; k < 3; k++) begin
            if (!win_valid && cand[scan_idx]) begin
                win_valid = 1'b1;
                win_idx   = scan_idx;
            end
            scan_idx = inc3(scan_idx);
        end
        win_ent = nonempty[win_idx] ? head_ent[win_idx] : in_ent[win_idx];
    end

    // Next bus state: rollback clears valid, stall holds, idle drops valid.
    always_comb begin
        rr_d         = rr_q;
        cdb_valid_d  = cdb_valid_q;
        cdb_rob_id_d = cdb_rob_id_q;
        cdb_result_d = cdb_result_q;
        cdb_src_d    = cdb_src_q;
        if (rollback_flag_i) begin
            cdb_valid_d = 1'b0;
            rr_d        = 2'd0;
        end else if (rdy_i) begin
            if (win_valid) begin
                cdb_valid_d  = 1'b1;
                cdb_rob_id_d = win_ent[ENT_W-1 -: ROB_ID_W];
                cdb_result_d = win_ent[DATA_W-1:0];
                cdb_src_d    = win_idx;
                rr_d         = inc3(win_idx);
            end else begin
                cdb_valid_d  = 1'b0;
            end
        end
    end

    // Registered bus outputs and round-robin pointer.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            rr_q         <= 2'd0;
            cdb_valid_q  <= 1'b0;
            cdb_rob_id_q <= '0;
            cdb_result_q <= '0;
            cdb_src_q    <= 2'd0;
        end else begin
            rr_q         <= rr_d;
            cdb_valid_q  <= cdb_valid_d;
            cdb_rob_id_q <= cdb_rob_id_d;
            cdb_result_q <= cdb_result_d;
            cdb_src_q    <= cdb_src_d;
        end
    end

    assign cdb_valid_o  = cdb_valid_q;
    assign cdb_rob_id_o = cdb_rob_id_q;
    assign cdb_result_o = cdb_result_q;
    assign cdb_src_o    = cdb_src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed scenarios plus randomized traffic, checked every
// cycle against a queue-based reference model of the CDB arbiter.
module tb_cdb_arbiter;

    localparam int DW = 32;
    localparam int TW = 5;
    localparam int QD = 2;
`ifdef CDB_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    typedef struct packed {
        logic [TW-1:0] tag;
        logic [DW-1:0] data;
    } ent_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic            rdy;
    logic            rollback;
    logic [2:0]      valid;
    logic [3*TW-1:0] rob_id;
    logic [3*DW-1:0] result;
    logic [2:0]      ready;
    logic            cdb_valid;
    logic [TW-1:0]   cdb_rob_id;
    logic [DW-1:0]   cdb_result;
    logic [1:0]      cdb_src;

    cdb_arbiter #(.DATA_W(DW), .ROB_ID_W(TW), .QDEPTH(QD)) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .rdy_i           (rdy),
        .rollback_flag_i (rollback),
        .req_valid_i     (valid),
        .req_rob_id_i    (rob_id),
        .req_result_i    (result),
        .req_ready_o     (ready),
        .cdb_valid_o     (cdb_valid),
        .cdb_rob_id_o    (cdb_rob_id),
        .cdb_result_o    (cdb_result),
        .cdb_src_o       (cdb_src)
    );

    int total = 0;
    int bad   = 0;

    // Reference model state: per-requester FIFOs and round-robin start index.
    ent_t          mq [3][$];
    ent_t          script [3][$];
    int            rr = 0;
    logic          exp_valid = 1'b0;
    logic [TW-1:0] exp_tag = '0;
    logic [DW-1:0] exp_data = '0;
    logic [1:0]    exp_src = 2'd0;
    bit            known = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit model_ready(input int i);
        return rdy && !rollback && (mq[i].size() < QD);
    endfunction

    task automatic add(input int i, input logic [TW-1:0] tag, input logic [DW-1:0] data);
        ent_t e;
        e.tag  = tag;
        e.data = data;
        script[i].push_back(e);
    endtask

    // Producers present the front of their script and hold it until accepted.
    task automatic drive();
        for (int i = 0; i < 3; i++) begin
            if (script[i].size() > 0) begin
                ent_t e;
                e = script[i][0];
                valid[i] = 1'b1;
                rob_id[i*TW +: TW] = e.tag;
                result[i*DW +: DW] = e.data;
            end else begin
                valid[i] = 1'b0;
                rob_id[i*TW +: TW] = TW'($urandom);
                result[i*DW +: DW] = $urandom;
            end
        end
    endtask

    // One clock edge of the behavioural model, using pre-edge inputs.
    task automatic model_step();
        bit   pushed [3];
        bit   bypassed [3];
        ent_t inc [3];
        ent_t e;
        int   w;
        if (!rst) begin
            for (int i = 0; i < 3; i++) mq[i].delete();
            rr = 0; exp_valid = 1'b0; exp_tag = '0; exp_data = '0; exp_src = 2'd0;
            known = 1'b1;
            return;
        end
        if (rollback) begin
            for (int i = 0; i < 3; i++) mq[i].delete();
            rr = 0; exp_valid = 1'b0;
            return;
        end
        if (!rdy) return;
        for (int i = 0; i < 3; i++) begin
            pushed[i]   = valid[i] && (mq[i].size() < QD);
            bypassed[i] = 1'b0;
            inc[i].tag  = rob_id[i*TW +: TW];
            inc[i].data = result[i*DW +: DW];
        end
        w = -1;
        for (int k = 0; k < 3; k++) begin
            int i;
            i = (rr + k) % 3;
            if (w < 0 && (mq[i].size() > 0 || (BYPASS && pushed[i]))) w = i;
        end
        if (w >= 0) begin
            if (mq[w].size() > 0) e = mq[w].pop_front();
            else begin
                e = inc[w];
                bypassed[w] = 1'b1;
            end
            exp_valid = 1'b1; exp_tag = e.tag; exp_data = e.data; exp_src = 2'(w);
            rr = (w + 1) % 3;
            $display("bcast t=%0t src=%0d tag=%0d data=%08h", $time, w, e.tag, e.data);
        end else begin
            exp_valid = 1'b0;
        end
        for (int i = 0; i < 3; i++) begin
            if (pushed[i] && !bypassed[i]) mq[i].push_back(inc[i]);
            if (pushed[i]) void'(script[i].pop_front());
        end
    endtask

    task automatic do_cycle();
        drive();
        #1;
        if (known)
            for (int i = 0; i < 3; i++)
                check($sformatf("req_ready[%0d]", i), 64'(ready[i]), 64'(model_ready(i)));
        @(posedge clk);
        model_step();
        #1;
        if (known) begin
            check("cdb_valid", 64'(cdb_valid), 64'(exp_valid));
            check("cdb_rob_id", 64'(cdb_rob_id), 64'(exp_tag));
            check("cdb_result", 64'(cdb_result), 64'(exp_data));
            check("cdb_src", 64'(cdb_src), 64'(exp_src));
        end
    endtask

    initial begin
        rst = 1'b0; rdy = 1'b0; rollback = 1'b0;
        valid = '0; rob_id = '0; result = '0;

        // Reset with all producers requesting.
        for (int i = 0; i < 3; i++) add(i, TW'(20 + i), $urandom);
        repeat (2) do_cycle();
        for (int i = 0; i < 3; i++) script[i].delete();
        rst = 1'b1; rdy = 1'b1;
        do_cycle();

        // Single ALU1 result.
        add(0, 5'd3, 32'hDEADBEEF);
        repeat (4) do_cycle();

        // Fairness: all three push for six cycles.
        for (int c = 0; c < 6; c++)
            for (int i = 0; i < 3; i++) add(i, TW'(1 + c * 3 + i), $urandom);
        repeat (16) do_cycle();

        // Backpressure on LSB while ALUs are busy.
        for (int c = 0; c < 3; c++) begin
            add(0, TW'(10 + c), $urandom);
            add(1, TW'(13 + c), $urandom);
        end
        add(2, 5'd5, $urandom); add(2, 5'd6, $urandom); add(2, 5'd7, $urandom);
        repeat (14) do_cycle();

        // Rollback with queued tags 1, 2, 4.
        add(0, 5'd1, $urandom); add(1, 5'd2, $urandom); add(2, 5'd4, $urandom);
        do_cycle();
        rollback = 1'b1;
        do_cycle();
        rollback = 1'b0;
        repeat (4) do_cycle();

        // Stall with pending tag 9.
        add(0, 5'd9, 32'h0000_0909);
        do_cycle();
        rdy = 1'b0;
        repeat (3) do_cycle();
        rdy = 1'b1;
        repeat (3) do_cycle();

        // Randomized traffic with stalls, rollbacks and occasional reset.
        for (int n = 0; n < 1500; n++) begin
            for (int i = 0; i < 3; i++)
                if (script[i].size() < 3 && $urandom_range(2, 0) != 0)
                    add(i, TW'($urandom_range(31, 1)), $urandom);
            rdy      = ($urandom_range(9, 0) != 0);
            rollback = ($urandom_range(39, 0) == 0);
            rst      = ($urandom_range(299, 0) != 0);
            do_cycle();
        end
        rst = 1'b1; rdy = 1'b1; rollback = 1'b0;
        repeat (12) do_cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
